botonconfig_multi: RTL
======================

Name: botonconfig_multi

Overview:
- Parametrised, multi-channel successor to the single-button configuration input block.
- Per channel it synchronises a raw push-button, debounces it and detects press events.
- Auto-repeat generates extra press events while a button is held.
- Press events drive Push_out, either latched until acknowledged through listo_rst or as a one-cycle pulse.
- Sits between the board push-buttons and the configuration/FSM logic, which consumes Push_out and answers with listo_rst.

Parameters:
- N_CH, 4: number of independent button channels (1..16).
- DEB_CYCLES, 16: consecutive stable synchronised samples required to accept a level change (>=2).
- REPEAT_DELAY, 64: hold cycles after the accepted press before the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 16: cycles between repeat events once repeating (>=1).
- LATCH_MODE, 1: 1 = Push_out held until listo_rst; 0 = Push_out is a one-cycle pulse and listo_rst is ignored.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is sampled on clk.
- button  input  N_CH  raw, asynchronous button levels, active-high.
- listo_rst  input  N_CH  per-channel acknowledge/clear of a latched Push_out, synchronous, active-high.
- Push_out  output  N_CH  per-channel press indication (latched or pulse, per LATCH_MODE).
- btn_level  output  N_CH  debounced button level.
- any_push  output  1  registered OR of Push_out, one cycle behind Push_out.

Behaviour:
- Reset (rst=0): sync flops, debounce counters, btn_level, Push_out, any_push and repeat counters are all 0; every FSM goes to IDLE.
- Synchroniser: 2-flop chain per channel. The output is sync, 2 edges after button is first sampled high.
- Debounce, per channel:
  - cnt (width clog2(DEB_CYCLES)) increments while sync != btn_level.
  - cnt clears to 0 on any cycle where sync == btn_level.
  - When sync != btn_level and cnt == DEB_CYCLES-1, btn_level toggles and cnt clears.
  - Glitches shorter than DEB_CYCLES samples never change btn_level.
  - Latency: btn_level rises DEB_CYCLES edges after sync rises.
- Press event ev (internal, one cycle):
  - Asserted on the rising edge of btn_level.
  - Also asserted on each repeat expiry.
  - Falling edges of btn_level generate no event.
- Repeat FSM, per channel; states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on btn_level rise; rcnt=0.
  - HOLD: rcnt increments each cycle. At rcnt == REPEAT_DELAY-1: ev, go to REPEAT, rcnt=0. If REPEAT_DELAY=0, stay in HOLD indefinitely.
  - REPEAT: rcnt increments. At rcnt == REPEAT_PERIOD-1: ev, rcnt=0.
  - Any state -> IDLE when btn_level=0, with rcnt cleared. Release has priority over a same-cycle expiry, which then produces no event.
- Push_out:
  - Registered; asserts on the edge following ev. Total latency from the first clk sampling button=1 to Push_out=1 is DEB_CYCLES+3 edges.
  - LATCH_MODE=1: set by ev, cleared by listo_rst. When ev and listo_rst coincide, ev wins and Push_out stays 1. Extra events while latched are absorbed, with no queueing. listo_rst while Push_out=0 has no effect.
  - LATCH_MODE=0: Push_out = ev delayed one cycle, high for exactly one cycle per event.
- Channels are fully independent; there is no arbitration between them.
- Reset mid-operation (counter in flight, Push_out latched, FSM in REPEAT): everything returns to reset values. A button still held after release of rst must re-debounce and produce a fresh press event.

Test Plan (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, N_CH=4, 20 ns clock):
- Reset: rst=0 with button=4'hF -> Push_out=0, btn_level=0, any_push=0 while rst is low. After release, btn_level[3:0]=F at edge 6 and Push_out=F at edge 7.
- Glitch rejection: ch0 pulse high for 3 cycles -> btn_level[0] and Push_out[0] stay 0. A clean 10-cycle press -> Push_out[0]=1 exactly 7 edges after the first sampled high.
- Latch/ack, LATCH_MODE=1: press ch1 -> Push_out[1] stays 1 across 50 cycles until listo_rst[1] pulses, then 0 the next edge. listo_rst[1] coinciding with a repeat event -> Push_out[1] stays 1.
- Auto-repeat, LATCH_MODE=0: hold ch2 for 60 cycles after btn_level rises -> pulses at offsets +1, +21, +29, +37, +45, +53. Release -> no further pulses and FSM returns to IDLE.
- Reset mid-operation: in REPEAT with Push_out[2]=1, assert rst for 2 cycles while ch2 is held -> all outputs are 0 immediately. Push_out[2] reasserts 7 edges after rst release.
- Independence: ch0 and ch3 pressed 2 cycles apart -> Push_out[0] and Push_out[3] rise 2 cycles apart. any_push follows their OR one cycle later. listo_rst[0] leaves Push_out[3] untouched.

Source files
------------

// File: rtl/botonconfig_multi.sv
// Multi-channel push-button front end: per channel it synchronises, debounces and detects
// presses, adds auto-repeat while a button is held, and drives a latched or pulsed press output.
module botonconfig_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned REPEAT_DELAY  = 64,
    parameter int unsigned REPEAT_PERIOD = 16,
    parameter int unsigned LATCH_MODE    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] listo_rst,
    output logic [N_CH-1:0] Push_out,
    output logic [N_CH-1:0] btn_level,
    output logic            any_push
);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    localparam int unsigned DW   = $clog2(DEB_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);
    localparam bit            LATCH_EN    = (LATCH_MODE != 0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]    sync_q;
        logic          sync;
        logic [DW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        state_e        state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          ev;
        logic          push_q, push_d;

        assign sync = sync_q[1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                state_q <= StIdle;
                rcnt_q  <= '0;
                push_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[0], button[i]};
                cnt_q   <= cnt_d;
                level_q <= level_d;
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                push_q  <= push_d;
            end
        end

        // Any sample agreeing with the current level restarts the stability count.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            if (sync != level_q) begin
                if (cnt_q == DEB_LAST) begin
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            if (!level_q) begin
                state_d = StIdle;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_d = StHold;
                        rcnt_d  = '0;
                    end
                    StHold: begin
                        if (REPEAT_EN) begin
                            if (rcnt_q == DELAY_LAST) begin
                                state_d = StRepeat;
                                rcnt_d  = '0;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                    end
                    StRepeat: rcnt_d = (rcnt_q == PERIOD_LAST) ? '0 : rcnt_q + 1'b1;
                    default: begin
                        state_d = StIdle;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // Release wins over a coincident expiry: no event unless the level is still high.
        always_comb begin
            ev = 1'b0;
            if (level_q) begin
                case (state_q)
                    StIdle:   ev = 1'b1;
                    StHold:   ev = REPEAT_EN && (rcnt_q == DELAY_LAST);
                    StRepeat: ev = (rcnt_q == PERIOD_LAST);
                    default:  ev = 1'b0;
                endcase
            end
        end

        always_comb begin
            push_d = ev;
            if (LATCH_EN) begin
                push_d = ev | (push_q & ~listo_rst[i]);
            end
        end

        assign Push_out[i]  = push_q;
        assign btn_level[i] = level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_push <= 1'b0;
        end else begin
            any_push <= |Push_out;
        end
    end

endmodule
